// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector.
// Pattern value, pattern length (1..PAT_W) and overlap mode are selectable
// at run time; din_valid qualifies input bits so gapped streams are allowed.
// A saturating match counter counts detections.
// Optional build macro SEQ_DET_REG_OUT_EN: when defined, y is registered and
// asserts one clock after the last pattern bit; otherwise y is the
// combinational (Mealy) match indication.
module seq_detect_param #(
  parameter int unsigned       PAT_W   = 8,
  parameter int unsigned       LEN_W   = 4,
  parameter int unsigned       CNT_W   = 8,
  parameter logic [PAT_W-1:0]  PAT_RST = 8'b0000_1101,
  parameter logic [LEN_W-1:0]  LEN_RST = 4'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] L_PAT_W    = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] L_FILL_MAX = LEN_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cfg_err;

  logic             w_accept;
  logic [PAT_W-1:0] w_win;
  logic [PAT_W-1:0] w_mask;
  logic             w_fill_ok;
  logic             w_pat_eq;
  logic             w_match;
  logic             w_len_bad;

  // A bit is taken into the window only when qualified and not in a load cycle.
  assign w_accept  = din_valid & ~load;
  assign w_win     = {r_hist, din};
  // Enough bits since the last clear: fill + 1 >= len (widened to avoid wrap).
  assign w_fill_ok = (({1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, r_len});
  assign w_pat_eq  = (((w_win ^ r_pat) & w_mask) == {PAT_W{1'b0}});
  // Gated by rst so y stays low throughout reset whatever the reset config.
  assign w_match   = rst & w_accept & ~r_cfg_err & w_fill_ok & w_pat_eq;
  assign w_len_bad = (len_in == {LEN_W{1'b0}}) || (len_in > L_PAT_W);

  // Compare mask selecting the low r_len bits of the window and pattern.
  always_comb begin
    w_mask = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      if (LEN_W'(i) < r_len) begin
        w_mask[i] = 1'b1;
      end else begin
        w_mask[i] = 1'b0;
      end
    end
  end

  // Pattern configuration and configuration-error flag, updated on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat     <= PAT_RST;
      r_len     <= LEN_RST;
      r_cfg_err <= 1'b0;
    end else if (load) begin
      r_pat     <= pat_in;
      r_len     <= len_in;
      r_cfg_err <= w_len_bad;
    end else begin
      r_pat     <= r_pat;
      r_len     <= r_len;
      r_cfg_err <= r_cfg_err;
    end
  end

  // Bit history and fill level; non-overlap matches restart the fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= {(PAT_W-1){1'b0}};
      r_fill <= {LEN_W{1'b0}};
    end else if (load) begin
      r_hist <= {(PAT_W-1){1'b0}};
      r_fill <= {LEN_W{1'b0}};
    end else if (w_accept) begin
      r_hist <= w_win[PAT_W-2:0];
      if (w_match && !overlap) begin
        r_fill <= {LEN_W{1'b0}};
      end else if (r_fill == L_FILL_MAX) begin
        r_fill <= r_fill;
      end else begin
        r_fill <= r_fill + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
    end
  end

  // Saturating match counter; a clear coinciding with a match leaves 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_cnt <= w_match ? L_CNT_ONE : {CNT_W{1'b0}};
    end else if (w_match && (r_cnt != L_CNT_MAX)) begin
      r_cnt <= r_cnt + L_CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;

`ifdef SEQ_DET_REG_OUT_EN
  logic r_y;

  // Registered match indication, one clock after the last pattern bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_match;
    end
  end

  assign y = r_y;
`else
  assign y = w_match;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios with fixed
// expectations plus a randomized run against a queue-based reference model.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap;
  logic       cnt_clr;
  logic       y;
  logic [7:0] match_cnt;
  logic       cfg_err;
  logic       y2;
  logic [1:0] match_cnt2;
  logic       cfg_err2;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_pat;
  int         m_len;
  bit         m_cfg;
  int         m_cnt;
  int         m_cnt2;
  bit         m_q[$];
  bit         exp_y;
  logic       obs_y;
  logic       obs_y2;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .y(y), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  // Expected detection: the latest len accepted bits (oldest first) spell the pattern MSB-first.
  function automatic bit model_match(bit d);
    int n;
    if (!rst || !din_valid || load || m_cfg) return 1'b0;
    if (m_q.size() < m_len - 1) return 1'b0;
    n = m_q.size();
    for (int k = 0; k < m_len - 1; k++) begin
      if (m_q[n - (m_len - 1) + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return d == m_pat[0];
  endfunction

  task automatic model_reset();
    m_pat = 8'h0D; m_len = 4; m_cfg = 1'b0; m_cnt = 0; m_cnt2 = 0;
    m_q.delete();
  endtask

  task automatic model_edge(bit mt);
    if (load) begin
      m_pat = pat_in; m_len = int'(len_in);
      m_cfg = (len_in == 4'd0) || (len_in > 4'd8);
      m_q.delete();
    end else if (din_valid) begin
      if (mt && !overlap) m_q.delete();
      else begin
        m_q.push_back(din);
        if (m_q.size() > 8) void'(m_q.pop_front());
      end
    end
    if (cnt_clr) begin
      m_cnt = mt ? 1 : 0; m_cnt2 = mt ? 1 : 0;
    end else if (mt) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  // Drives one cycle starting at posedge+1, captures y, advances the model.
  task automatic step(input bit d, input bit v, input bit ld, input bit clr);
    din = d; din_valid = v; load = ld; cnt_clr = clr;
    @(negedge clk);
    exp_y = model_match(d);
`ifndef SEQ_DET_REG_OUT_EN
    obs_y = y; obs_y2 = y2;
`endif
    @(posedge clk);
    model_edge(exp_y);
    #1;
`ifdef SEQ_DET_REG_OUT_EN
    obs_y = y; obs_y2 = y2;
`endif
    din_valid = 1'b0; load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 1'b1; din_valid = 1'b1; load = 1'b0; cnt_clr = 1'b0;
    overlap = 1'b1; pat_in = 8'h00; len_in = 4'd0;
    model_reset();
    #2;
    n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL reset_y got %b want 0", y); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg got %b want 0", cfg_err); end
    @(posedge clk); #1;
    din_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_overlap();
    bit s[11] = '{1,1,0,1,1,0,1,1,1,0,1};
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(s[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_y !== ((i == 3) || (i == 6) || (i == 10))) begin
        n_err++; $display("FAIL ovl_y bit %0d got %b", i, obs_y);
      end
    end
    n_cmp++; if (match_cnt !== 8'd3) begin n_err++; $display("FAIL ovl_cnt got %0d want 3", match_cnt); end
  endtask

  task automatic test_non_overlap();
    bit s[11] = '{1,1,0,1,1,0,1,1,1,0,1};
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(s[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_y !== ((i == 3) || (i == 10))) begin
        n_err++; $display("FAIL novl_y bit %0d got %b", i, obs_y);
      end
    end
    n_cmp++; if (match_cnt !== 8'd2) begin n_err++; $display("FAIL novl_cnt got %0d want 2", match_cnt); end
  endtask

  task automatic test_gaps();
    bit s[11] = '{1,1,0,1,1,0,1,1,1,0,1};
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(s[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_y !== ((i == 3) || (i == 6) || (i == 10))) begin
        n_err++; $display("FAIL gap_y bit %0d got %b", i, obs_y);
      end
      for (int g = 0; g < 2; g++) begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_y !== 1'b0) begin n_err++; $display("FAIL gap_idle bit %0d got %b want 0", i, obs_y); end
      end
    end
    n_cmp++; if (match_cnt !== 8'd3) begin n_err++; $display("FAIL gap_cnt got %0d want 3", match_cnt); end
  endtask

  task automatic test_len1_cfg();
    bit s[4] = '{0,1,1,0};
    pat_in = 8'h00; len_in = 4'd1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (obs_y !== 1'b0) begin n_err++; $display("FAIL load_y got %b want 0", obs_y); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL len1_cfg got %b want 0", cfg_err); end
    for (int i = 0; i < 4; i++) begin
      step(s[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_y !== ((i == 0) || (i == 3))) begin
        n_err++; $display("FAIL len1_y bit %0d got %b", i, obs_y);
      end
    end
    len_in = 4'd0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL len0_cfg got %b want 1", cfg_err); end
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      n_cmp++; if (obs_y !== 1'b0) begin n_err++; $display("FAIL len0_y bit %0d got %b want 0", i, obs_y); end
    end
    len_in = 4'd9;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL len9_cfg got %b want 1", cfg_err); end
    pat_in = 8'h0D; len_in = 4'd4;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL restore_cfg got %b want 0", cfg_err); end
  endtask

  task automatic test_saturate();
    bit s[3] = '{1,0,1};
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", match_cnt); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) step(s[i], 1'b1, 1'b0, 1'b0);
      n_cmp++; if (obs_y !== 1'b1) begin n_err++; $display("FAIL sat_y match %0d got %b want 1", r, obs_y); end
    end
    n_cmp++; if (match_cnt2 !== 2'd3) begin n_err++; $display("FAIL sat_cnt2 got %0d want 3", match_cnt2); end
    n_cmp++; if (match_cnt !== 8'd5) begin n_err++; $display("FAIL sat_cnt got %0d want 5", match_cnt); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (obs_y2 !== 1'b1) begin n_err++; $display("FAIL clrm_y got %b want 1", obs_y2); end
    n_cmp++; if (match_cnt2 !== 2'd1) begin n_err++; $display("FAIL clrm_cnt2 got %0d want 1", match_cnt2); end
    n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL clrm_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_async_reset();
    bit s[4] = '{1,1,0,1};
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    din = 1'b1; din_valid = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (y !== 1'b0) begin n_err++; $display("FAIL arst_y got %b want 0", y); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL arst_cnt got %0d want 0", match_cnt); end
    n_cmp++; if (match_cnt2 !== 2'd0) begin n_err++; $display("FAIL arst_cnt2 got %0d want 0", match_cnt2); end
    @(posedge clk); #1;
    din_valid = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (obs_y !== 1'b0) begin n_err++; $display("FAIL arst_single got %b want 0", obs_y); end
    for (int i = 0; i < 4; i++) begin
      step(s[i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_y !== (i == 3)) begin n_err++; $display("FAIL arst_seq bit %0d got %b", i, obs_y); end
    end
    n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL arst_seq_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_random();
    bit ld;
    for (int i = 0; i < 600; i++) begin
      overlap = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 39) == 0);
      if (ld) begin
        pat_in = 8'($urandom);
        len_in = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 4));
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ld, ($urandom_range(0, 29) == 0));
      n_cmp++; if (obs_y !== exp_y) begin n_err++; $display("FAIL rnd_y cyc %0d got %b want %b", i, obs_y, exp_y); end
      n_cmp++; if (match_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, match_cnt, m_cnt); end
      n_cmp++; if (match_cnt2 !== 2'(m_cnt2)) begin n_err++; $display("FAIL rnd_cnt2 cyc %0d got %0d want %0d", i, match_cnt2, m_cnt2); end
      n_cmp++; if (cfg_err !== m_cfg) begin n_err++; $display("FAIL rnd_cfg cyc %0d got %b want %b", i, cfg_err, m_cfg); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_len1_cfg();
    test_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised, runtime-programmable serial pattern detector. Successor to the fixed 1101 Mealy detector.
- Pattern value, pattern length (1..PAT_W) and overlap mode are selectable at run time. A valid qualifier allows gapped input streams.
- A saturating match counter is included.
- Sits on a serial bit stream ahead of framing/control logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length field; must hold PAT_W
CNT_W, 8, match counter width
PAT_RST, 8'b0000_1101, pattern value after reset (LSB-aligned)
LEN_RST, 4, pattern length after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
din  in  1  serial data bit
din_valid  in  1  din is sampled only when 1
load  in  1  pulse: capture pat_in/len_in, clear history
pat_in  in  PAT_W  new pattern, LSB-aligned; bit len-1 is the first bit received
len_in  in  LEN_W  new pattern length
overlap  in  1  1 = overlapping matches, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_cnt
y  out  1  match indication
match_cnt  out  CNT_W  saturating count of matches
cfg_err  out  1  1 while stored length is 0 or >PAT_W

Behaviour:
- Reset (rst=0, async):
  - pat_r=PAT_RST, len_r=LEN_RST.
  - hist=0, fill=0, match_cnt=0, cfg_err=0; y=0 while in reset.
- State:
  - hist: PAT_W-1 most recent accepted bits, newest in LSB.
  - fill: number of valid history bits, 0..PAT_W-1.
- Accept condition: din_valid=1 and load=0.
- Window = {hist, din}. Match when all of the following hold:
  - accept=1
  - cfg_err=0
  - fill >= len_r-1
  - window[len_r-1:0] == pat_r[len_r-1:0]
- Output y equals match combinationally (Mealy). y is 0 whenever din_valid=0.
- On accept without match:
  - hist <= {hist, din} (shift left).
  - fill <= min(fill+1, PAT_W-1).
- On match:
  - overlap=1: hist and fill update exactly as with no match.
  - overlap=0: fill <= 0, so the next match needs len_r fresh bits; hist contents are don't-care.
- overlap is sampled every cycle. Changing it mid-stream affects only the next match.
- Load cycle:
  - pat_r <= pat_in, len_r <= len_in, fill <= 0.
  - din is ignored and y=0.
  - cfg_err <= (len_in==0 || len_in>PAT_W), registered from the next cycle.
- cfg_err=1: no matches ever occur. History still shifts.
- match_cnt:
  - Increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr and match in the same cycle: match_cnt <= 1.
  - cnt_clr alone: match_cnt <= 0.
- len_r=1: every accepted bit equal to pat_r[0] matches, regardless of fill.
- Latency: y in the same cycle as the last pattern bit; match_cnt updates at the following clock edge.
- din_valid=0 cycles hold hist, fill and match_cnt. Gaps never break a partial match.

Optional Feature:
SEQ_DET_REG_OUT_EN
- Defined: y is registered (y <= match at the clock edge) and asserts one cycle after the last pattern bit. Registered y resets to 0. match_cnt timing is unchanged.
- Undefined: y is the combinational Mealy output described above.

Test Plan:
1. Reset defaults (1101, len 4), overlap=1, stream 11011011101 one bit per cycle -> y=1 on bits 3, 6 and 10 (0-based); match_cnt=3.
2. Same stream with overlap=0 -> y=1 on bits 3 and 10 only; match_cnt=2.
3. Scenario 1 with din_valid=0 inserted for 2 cycles after every bit -> y=1 only on the valid cycles of bits 3, 6 and 10; match_cnt=3; y=0 on all gap cycles.
4. Load pat_in=0, len_in=1, then stream 0110 -> y=1 on bits 0 and 3. Then load len_in=0 -> cfg_err=1, y stays 0 on any stream.
5. CNT_W=2 instance, 5 overlapping 1101 matches -> match_cnt saturates at 3. Assert cnt_clr on the cycle of a match -> match_cnt=1.
6. Drive rst=0 asynchronously mid-pattern after 110 -> outputs clear immediately. After release, sending 1 alone gives no y; a full 1101 is required to assert y.
